// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the ARM instruction fetch stage.
package arm_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [31:0] R15_OFFSET = 32'd8;

endpackage

// File: rtl/arm_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// imem req/ack and hands it to decode with valid/stall, plus R15 and link values.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | just out of reset, no request yet
// FETCH | request outstanding at imem_addr, data will be kept
// VALID | instr presented to decode, no request
// DRAIN | request outstanding but redirected, its data will be discarded
module arm_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_plus8
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, ipc, fetch_addr, target_aligned;
  logic         fetch_done;

  assign target_aligned = branch_target & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // An ack in DRAIN always completes the stale request, so it returns to
  // FETCH even when a newer redirect arrives in the same cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (branch_valid)  state_next = imem_ack ? FETCH : DRAIN;
        else if (imem_ack) state_next = VALID;
      end
      VALID: begin
        if (branch_valid || !stall) state_next = FETCH;
      end
      DRAIN: begin
        if (imem_ack) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH) || (state == DRAIN);
    instr_valid = (state == VALID);
  end

  always_comb begin
    pc_next    = pc;
    fetch_done = 1'b0;
    if (state != IDLE && branch_valid) begin
      pc_next = target_aligned;
    end else if (state == FETCH && imem_ack) begin
      pc_next    = pc + PC_INC;
      fetch_done = 1'b1;
    end
  end

  // fetch_addr only moves when a fresh request starts, so imem_addr holds
  // the old address through DRAIN while pc tracks the redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ipc        <= RESET_PC;
      instr      <= 32'h0;
      fetch_addr <= RESET_PC;
    end else begin
      pc <= pc_next;
      if (fetch_done) begin
        instr <= imem_rdata;
        ipc   <= pc;
      end
      if (state_next == FETCH) fetch_addr <= pc_next;
    end
  end

  assign imem_addr = fetch_addr;
  assign pc_plus4  = ipc + PC_INC;
  assign pc_plus8  = ipc + R15_OFFSET;

endmodule
